// File: rtl/keypad_entry_pkg.sv
// keypad_entry_pkg: scan FSM states, key codes and the 4x4 keypad map
package keypad_entry_pkg;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    localparam logic [3:0] KEY_0 = 4'd0, KEY_1 = 4'd1, KEY_2 = 4'd2, KEY_3 = 4'd3, KEY_4 = 4'd4;
    localparam logic [3:0] KEY_5 = 4'd5, KEY_6 = 4'd6, KEY_7 = 4'd7, KEY_8 = 4'd8, KEY_9 = 4'd9;
    localparam logic [3:0] KEY_A = 4'd10, KEY_B = 4'd11, KEY_C = 4'd12;
    localparam logic [3:0] KEY_BKSP = 4'd13, KEY_CLEAR = 4'd14, KEY_ENTER = 4'd15;
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [63:0] map;
        map = {KEY_BKSP, KEY_ENTER, KEY_0, KEY_CLEAR,
               KEY_C,    KEY_9,     KEY_8, KEY_7,
               KEY_B,    KEY_6,     KEY_5, KEY_4,
               KEY_A,    KEY_3,     KEY_2, KEY_1};
        return map[{row, col, 2'b00} +: 4];
    endfunction
endpackage

// File: rtl/keypad_entry_bcd_to_bin.sv
// bcd_to_bin: three-digit BCD to binary, h*100 + t*10 + o
module bcd_to_bin (
    input  logic [11:0] bcd,
    output logic [9:0]  bin
);
    assign bin = 10'(bcd[11:8]) * 10'd100 + 10'(bcd[7:4]) * 10'd10 + 10'(bcd[3:0]);
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 keypad scan, debounce and 3-digit decimal entry; KEYPAD_BACKSPACE_EN makes D a backspace
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_tick,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic [11:0] digits,
    output logic [7:0]  value,
    output logic        value_valid,
    output logic        overflow
);
    localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);
    state_t state, state_nx;
    logic [3:0] col_m, col_s, cnt, cnt_nx, row_nx, rot, key;
    logic [1:0] kr, kc, kr_nx, kc_nx, low_col, cur_row, count;
    logic any_low, accept, commit;
    logic [11:0] cand, conv_in;
    logic [9:0] conv;

    assign any_low = ~&col_s;
    assign low_col = col_s[0] ? (col_s[1] ? (col_s[2] ? 2'd3 : 2'd2) : 2'd1) : 2'd0;
    assign cur_row = row_n[0] ? (row_n[1] ? (row_n[2] ? 2'd3 : 2'd2) : 2'd1) : 2'd0;
    assign rot = {row_n[2:0], row_n[3]};

    // two-flop synchronizer for the asynchronous column senses
    always_ff @(posedge clk or posedge reset)
        if (reset) {col_m, col_s} <= 8'hFF;
        else       {col_m, col_s} <= {col_n, col_m};

    // next-state: row rotation, key latch, debounce/release counting and acceptance
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        row_nx   = row_n;
        kr_nx    = kr;
        kc_nx    = kc;
        accept   = 1'b0;
        key      = key_map(kr, kc);
        if (scan_tick)
            case (state)
                SCAN:
                    if (any_low) begin
                        kr_nx    = cur_row;
                        kc_nx    = low_col;
                        cnt_nx   = 4'd1;
                        key      = key_map(cur_row, low_col);
                        accept   = DT == 4'd1;
                        state_nx = accept ? HELD : DEBOUNCE;
                    end else row_nx = rot;
                DEBOUNCE:
                    if (!col_s[kc]) begin
                        cnt_nx   = cnt + 4'd1;
                        accept   = cnt_nx == DT;
                        state_nx = accept ? HELD : DEBOUNCE;
                    end else state_nx = SCAN;
                HELD:
                    if (!any_low) begin
                        cnt_nx   = 4'd1;
                        state_nx = DT == 4'd1 ? SCAN : RELEASE;
                        row_nx   = DT == 4'd1 ? rot : row_n;
                    end
                RELEASE:
                    if (any_low) state_nx = HELD;
                    else begin
                        cnt_nx   = cnt + 4'd1;
                        state_nx = cnt_nx == DT ? SCAN : RELEASE;
                        row_nx   = cnt_nx == DT ? rot : row_n;
                    end
                default: state_nx = SCAN;
            endcase
    end

    // scan FSM state register
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= SCAN;
            cnt   <= 4'd0;
            row_n <= 4'b1110;
            kr    <= 2'd0;
            kc    <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            row_n <= row_nx;
            kr    <= kr_nx;
            kc    <= kc_nx;
        end

    assign cand    = {digits[7:0], key};
    assign commit  = accept && key == KEY_ENTER;
    assign conv_in = commit ? digits : cand;

    bcd_to_bin u_conv (.bcd(conv_in), .bin(conv));

    // entry datapath: digit append with range check, commit, clear and optional backspace
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            digits      <= 12'd0;
            count       <= 2'd0;
            value       <= 8'd0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            value_valid <= commit;
            if (accept) begin
                if (key <= KEY_9) begin
                    if (count < 2'd3 && conv <= 10'd255) begin
                        digits <= cand;
                        count  <= count + 2'd1;
                    end else overflow <= 1'b1;
                end else if (commit) begin
                    value    <= conv[7:0];
                    digits   <= 12'd0;
                    count    <= 2'd0;
                    overflow <= 1'b0;
                end else if (key == KEY_CLEAR) begin
                    digits   <= 12'd0;
                    count    <= 2'd0;
                    overflow <= 1'b0;
                end
`ifdef KEYPAD_BACKSPACE_EN
                else if (key == KEY_BKSP && count != 2'd0) begin
                    digits   <= {4'd0, digits[11:4]};
                    count    <= count - 2'd1;
                    overflow <= 1'b0;
                end
`else
`endif
            end
        end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed keypad presses with a scoreboard of expected committed values
module tb_keypad_entry;
    logic clk = 1'b0, reset = 1'b1, scan_tick = 1'b0;
    logic [3:0] col_n, row_n;
    logic [11:0] digits;
    logic [7:0] value;
    logic value_valid, overflow;
    logic pressed = 1'b0;
    logic [1:0] pr = 2'd0, pc = 2'd0;
    logic [7:0] sb[$];
    int checks = 0, errors = 0;

    keypad_entry #(.DEBOUNCE_TICKS(4)) dut (
        .clk(clk), .reset(reset), .scan_tick(scan_tick), .col_n(col_n), .row_n(row_n),
        .digits(digits), .value(value), .value_valid(value_valid), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // matrix model: the pressed switch shorts its row drive onto its column
    assign col_n = (pressed && !row_n[pr]) ? ~(4'b0001 << pc) : 4'hF;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        repeat (3) @(negedge clk);
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        pr = r;
        pc = c;
        pressed = 1'b1;
        repeat (10) tick();
        pressed = 1'b0;
        repeat (6) tick();
    endtask

    // scoreboard: every value_valid pulse must match the oldest expected commit
    always @(negedge clk)
        if (value_valid === 1'b1) begin
            chk("commit_expected", 12'(sb.size() != 0), 12'd1);
            if (sb.size() != 0) chk("commit_value", 12'(value), 12'(sb.pop_front()));
        end

    initial begin
        logic found;
        repeat (3) @(negedge clk);
        chk("rst_row_n", 12'(row_n), 12'h00E);
        chk("rst_digits", digits, 12'h000);
        chk("rst_value", 12'(value), 12'd0);
        chk("rst_valid", 12'(value_valid), 12'd0);
        chk("rst_overflow", 12'(overflow), 12'd0);
        reset = 1'b0;
        repeat (2) tick();
        press(2'd0, 2'd0);
        chk("d1", digits, 12'h001);
        press(2'd0, 2'd1);
        chk("d12", digits, 12'h012);
        press(2'd2, 2'd1);
        chk("d128", digits, 12'h128);
        sb.push_back(8'd128);
        press(2'd3, 2'd2);
        chk("after_128_digits", digits, 12'h000);
        press(2'd0, 2'd1);
        press(2'd1, 2'd1);
        press(2'd1, 2'd2);
        chk("d256_digits", digits, 12'h025);
        chk("d256_overflow", 12'(overflow), 12'd1);
        sb.push_back(8'd25);
        press(2'd3, 2'd2);
        chk("after_25_overflow", 12'(overflow), 12'd0);
        pr = 2'd1;
        pc = 2'd1;
        for (int i = 0; i < 8; i++) begin
            pressed = ~pressed;
            tick();
        end
        pressed = 1'b0;
        chk("bounce_no_accept", digits, 12'h000);
        press(2'd1, 2'd1);
        chk("bounce_one_5", digits, 12'h005);
        pr = 2'd2;
        pc = 2'd0;
        pressed = 1'b1;
        repeat (20) tick();
        chk("hold7_row_mid", 12'(row_n), 12'h00B);
        repeat (19) tick();
        chk("hold7_row_end", 12'(row_n), 12'h00B);
        chk("hold7_digits", digits, 12'h057);
        pressed = 1'b0;
        repeat (6) tick();
        chk("hold7_no_repeat", digits, 12'h057);
        press(2'd3, 2'd0);
        chk("clear_digits", digits, 12'h000);
        press(2'd2, 2'd2);
        press(2'd3, 2'd0);
        sb.push_back(8'd0);
        press(2'd3, 2'd2);
        press(2'd1, 2'd0);
        press(2'd0, 2'd1);
        press(2'd3, 2'd3);
`ifdef KEYPAD_BACKSPACE_EN
        chk("bksp_digits", digits, 12'h004);
        sb.push_back(8'd4);
`else
        chk("bksp_digits", digits, 12'h042);
        sb.push_back(8'd42);
`endif
        press(2'd3, 2'd2);
        press(2'd3, 2'd1);
        press(2'd3, 2'd1);
        press(2'd2, 2'd0);
        chk("lead0_digits", digits, 12'h007);
        press(2'd0, 2'd0);
        chk("lead0_fourth_rejected", digits, 12'h007);
        chk("lead0_overflow", 12'(overflow), 12'd1);
        sb.push_back(8'd7);
        press(2'd3, 2'd2);
        chk("lead0_value", 12'(value), 12'd7);
        pr = 2'd0;
        pc = 2'd2;
        pressed = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            tick();
            found = row_n === 4'b1110;
        end
        chk("rst3_row_found", 12'(found), 12'd1);
        tick();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pressed = 1'b0;
        chk("rst3_row_n", 12'(row_n), 12'h00E);
        chk("rst3_digits", digits, 12'h000);
        chk("rst3_value", 12'(value), 12'd0);
        chk("rst3_valid", 12'(value_valid), 12'd0);
        chk("rst3_overflow", 12'(overflow), 12'd0);
        repeat (6) tick();
        chk("rst3_no_digit", digits, 12'h000);
        chk("sb_drained", 12'(sb.size()), 12'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Input-side counterpart of the display path: scans a 4x4 matrix keypad through active-low row drives and column senses, debounces presses, and builds a decimal number of up to three digits entered by the user. On Enter it converts the BCD entry to binary and presents an 8-bit value with a one-cycle valid strobe, for loading into the CPU or its RAM. It sits beside the clock divider and uses a slow scan tick, mirroring the digit-scan output.

## Interface
- DEBOUNCE_TICKS, 4: consecutive scan ticks a level must be stable before it is accepted; legal range 1–15.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- scan_tick  in  1  one-clk-wide enable pulse; all scan, debounce and sample activity occurs only on cycles where it is high.
- col_n  in  4  column senses, active-low, externally pulled up; asynchronous to clk.
- row_n  out  4  row drives, active-low, exactly one low while scanning.
- digits  out  12  current entry as BCD {hundreds, tens, ones}, for display.
- value  out  8  last committed binary value; holds until the next commit.
- value_valid  out  1  high for exactly one clk cycle after a commit.
- overflow  out  1  sticky flag: a digit was rejected because the entry would exceed 255 or three digits.

## Operation
- col_n passes through a 2-flop synchronizer; the FSM sees only the synchronized value, sampled on scan_tick.
- Key map (row, col): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: * 0 # D. If several columns are low, the lowest column index wins.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
  - SCAN: on each tick, if any column is low, latch (row, col), set cnt=1, and go to DEBOUNCE; row_n stays frozen. Otherwise rotate row_n 1110→1101→1011→0111→1110.
  - DEBOUNCE: on each tick, if the latched column is still low, cnt++; otherwise return to SCAN and resume rotation. When cnt reaches DEBOUNCE_TICKS, accept the key once and go to HELD. With DEBOUNCE_TICKS=1, the key is accepted on the detection tick itself, with no DEBOUNCE dwell.
  - HELD: on a tick where all columns are high, set cnt=1 and go to RELEASE.
  - RELEASE: on a tick where any column is low, return to HELD. After DEBOUNCE_TICKS consecutive all-high ticks, go to SCAN and advance to the next row.
- Actions on acceptance:
  - Digit d: let cand = {digits[7:0], d}. Accept iff the digit count is below 3 and bcd_to_bin(cand) ≤ 255; then digits ← cand and count++. Otherwise digits is unchanged and overflow ← 1.
  - '#': value ← bcd_to_bin(digits)[7:0], pulse value_valid, then clear digits, count and overflow. An empty entry commits 0.
  - '*': clear digits, count and overflow; value is unchanged.
  - A/B/C: ignored. D: see Configuration.
- A leading 0 counts as a digit: "0","0","7" gives count=3 and binary value 7.

## Timing
- Reset values: row_n=1110, digits=0, value=0, value_valid=0, overflow=0, state=SCAN, cnt=0, count=0. Synchronizer flops reset to 1111.
- Column-to-FSM latency: 2 clk for synchronization, plus the wait for the next scan_tick.
- Acceptance takes effect at the clk edge of the accepting scan_tick. value and digits change at that edge, and value_valid is high for the following clk cycle only.
- Holding a key longer produces no repeat. Chatter during RELEASE only extends the release wait.
- Reset asserted mid-debounce or mid-hold discards the pending key; no action is produced.
- Ticks on consecutive clks are legal and behave identically.

## Configuration
- KEYPAD_BACKSPACE_EN
  - Defined: key D is backspace. If count > 0, digits ← {4'd0, digits[11:4]}, count-- and overflow ← 0. If count = 0, D is a no-op.
  - Undefined: D is ignored like A–C, and no backspace logic is synthesized.

## Structure
- Shared package holds the FSM state encoding, the key-code constants (KEY_ENTER, KEY_CLEAR, KEY_BKSP, digit 0–9 codes) and the 4x4 key-map function.
- Sub-module bcd_to_bin: combinational, 12-bit BCD in, 10-bit binary out, computed as h*100 + t*10 + o. It is the inverse of the display's binary-to-BCD converter and is instantiated once, on cand or on digits as selected.

## Test plan
All scenarios use DEBOUNCE_TICKS=4.
- Press "1","2","8","#", each held 6 ticks and released 6 ticks → value=128 (0x80), a single value_valid pulse, digits=0 afterwards.
- Press "2","5","6" → the third digit is rejected: digits=0x025 and overflow=1. Then "#" → value=25 and overflow=0.
- Press "5" and bounce it low/high/low/high on alternating ticks, then hold steady for 4 ticks → exactly one digit 5 is accepted; the bounce-phase ticks do not accept.
- Hold "7" for 40 ticks → digits=0x007 with no repeats, and row_n stays frozen at 1011 until release completes.
- Press "9","*","#" → value=0 with one value_valid pulse. Assert reset for 1 clk during the DEBOUNCE of a "3" → no digit is entered and all outputs are at their reset values.
- With KEYPAD_BACKSPACE_EN: "4","2",D,"#" → value=4. Without it, the same sequence → value=42.
